multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1: 1 = an unknown opcode enters HALT; 0 = an unknown opcode returns to FETCH as a no-op.
REQ-002 clock  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register; sampled in DECODE.
REQ-005 mem_ready  input  1  memory completion strobe for the current read or write access.
REQ-006 PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls (MIPS multicycle meaning).
REQ-007 ALUOp, ALUSrcB, PCSource  output  2 each  datapath controls.
REQ-008 state  output  4  current state encoding, for debug.
REQ-009 halted  output  1  high while in HALT.

Function
REQ-010 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, IEXEC, IWB, BRANCH, JUMP, HALT.
REQ-011 Controls not listed for a state SHALL be 0 in that state; all outputs SHALL be Moore outputs of state only, except the ready-gated strobes in REQ-012 and REQ-016.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-014 DECODE next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 001000 -> IEXEC; 000100 or 000101 -> BRANCH; 000010 -> JUMP; any other opcode -> HALT or FETCH per HALT_ON_ILLEGAL.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD for lw, MEMWR for sw. The opcode SHALL be latched in DECODE; later opcode changes are ignored.
REQ-016 MEMRD: MemRead=1, IorD=1; wait while mem_ready=0, then go to MEMWB. MEMWR: MemWrite=1, IorD=1; wait while mem_ready=0, then go to FETCH.
REQ-017 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
REQ-019 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state IWB. IWB: RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=(latched opcode==000101); next state FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-022 HALT: all controls 0, halted=1; exit only via reset.
REQ-023 Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3; each wait cycle adds 1.
REQ-024 MemRead and MemWrite SHALL never be asserted in the same cycle.

Reset
REQ-025 reset=1 at a rising edge SHALL force FETCH, clear the latched opcode to 000000, and clear halted, from any state, including mid-wait in MEMRD/MEMWR.
REQ-026 During and immediately after reset, PCWrite, IRWrite, MemWrite and RegWrite SHALL stay 0 until FETCH is entered with mem_ready=1.

Structure
REQ-027 State encodings and opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI) SHALL live in shared package mips_pkg.
REQ-028 One sub-module, mc_outdec, SHALL be the combinational decode from state to controls; the FSM register and next-state logic SHALL stay in multicycle_ctrl.

Verification
REQ-029 lw (100011), mem_ready=1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-030 sw, mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles; FETCH on the cycle after mem_ready rises; RegWrite never 1.
REQ-031 bne (000101) -> BRANCH with PCWriteCond=1, BranchNe=1, PCSource=01; beq -> BranchNe=0.
REQ-032 opcode 111111, HALT_ON_ILLEGAL=1 -> halted=1 held for 20 cycles; reset -> FETCH, halted=0.
REQ-033 reset asserted during MEMRD wait -> FETCH on the next edge; no RegWrite pulse.
REQ-034 FETCH with mem_ready=0 for 2 cycles -> IRWrite and PCWrite stay 0 until the ready cycle, then pulse for exactly 1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle controller: FSM states, opcodes and
// the control bundle that the output decoder drives.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control decode; outputs are Moore except the
// FETCH IRWrite/PCWrite strobes, which follow mem_ready in the same cycle.
module mc_outdec
  import mips_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_is_bne,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = 2'b10;
      end
      S_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
      end
      S_IWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = 2'b01;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = 2'b01;
        o_ctrl.branch_ne     = i_is_bne;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = 2'b10;
      end
      S_HALT: begin
        o_ctrl.halted = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// MIPS multicycle control FSM: one state per cycle, MEMRD/MEMWR/FETCH stall
// until mem_ready; opcode is captured in DECODE and held for later states.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       halted
);

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_opcode;
  ctrl_t      w_ctrl;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_opcode <= OP_RTYPE;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   w_next_state = S_MEMADR;
          OP_RTYPE:       w_next_state = S_EXEC;
          OP_ADDI:        w_next_state = S_IEXEC;
          OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
          OP_J:           w_next_state = S_JUMP;
          default:        w_next_state = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
        endcase
      end
      // r_opcode already holds the DECODE-cycle opcode here
      S_MEMADR: w_next_state = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_RWB;
      S_RWB:    w_next_state = S_FETCH;
      S_IEXEC:  w_next_state = S_IWB;
      S_IWB:    w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_is_bne    (r_opcode == OP_BNE),
    .o_ctrl      (w_ctrl)
  );

  // Architectural write strobes are suppressed while reset is held so a
  // stale state cannot commit anything during the reset cycle.
  assign PCWrite     = w_ctrl.pc_write  & ~reset;
  assign IRWrite     = w_ctrl.ir_write  & ~reset;
  assign MemWrite    = w_ctrl.mem_write & ~reset;
  assign RegWrite    = w_ctrl.reg_write & ~reset;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign BranchNe    = w_ctrl.branch_ne;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegDst      = w_ctrl.reg_dst;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUOp       = w_ctrl.alu_op;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign PCSource    = w_ctrl.pc_source;
  assign halted      = w_ctrl.halted;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream against an instruction-level reference model;
// per-cycle expectations are queued by the driver and checked by a monitor.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       halted;
    logic       pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] aluop, asb, pcs;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic       rst;
    obs_t       e;
  } rec_t;

  logic       clock, reset, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, halted;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] state;

  rec_t plan[$];
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .state(state), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reset held during a cycle blocks every architectural write strobe.
  task automatic add(input logic [5:0] op, input logic rdy, input logic rst, input obs_t e);
    rec_t r;
    r.op = op;
    r.rdy = rdy;
    r.rst = rst;
    r.e = e;
    if (rst) begin
      r.e.pcw = 1'b0;
      r.e.irw = 1'b0;
      r.e.mw  = 1'b0;
      r.e.rw  = 1'b0;
    end
    plan.push_back(r);
  endtask

  function automatic obs_t fetch_o(input logic go);
    obs_t o;
    o = blank(S_FETCH);
    o.mr  = 1'b1;
    o.asb = 2'b01;
    o.irw = go;
    o.pcw = go;
    return o;
  endfunction

  // One instruction from FETCH until the model is back at FETCH (or reset).
  // rst_at: index of the memory wait cycle at which reset is asserted (-1 none).
  task automatic do_instr(input logic [5:0] op, input int fwait, input int mwait,
                          input int rst_at, input int halt_cycles);
    obs_t o;
    bit   is_lw;
    for (int w = 0; w < fwait; w++) add(rnd_op(), 1'b0, 1'b0, fetch_o(1'b0));
    add(rnd_op(), 1'b1, 1'b0, fetch_o(1'b1));
    o = blank(S_DECODE);
    o.asb = 2'b11;
    add(op, rnd_bit(), 1'b0, o);
    case (op)
      6'b100011, 6'b101011: begin
        is_lw = (op == 6'b100011);
        o = blank(S_MEMADR);
        o.asa = 1'b1;
        o.asb = 2'b10;
        add(rnd_op(), rnd_bit(), 1'b0, o);
        o = blank(is_lw ? S_MEMRD : S_MEMWR);
        o.iord = 1'b1;
        if (is_lw) o.mr = 1'b1;
        else       o.mw = 1'b1;
        for (int w = 0; w < mwait; w++) begin
          if (w == rst_at) begin
            add(rnd_op(), 1'b0, 1'b1, o);
            return;
          end
          add(rnd_op(), 1'b0, 1'b0, o);
        end
        add(rnd_op(), 1'b1, 1'b0, o);
        if (is_lw) begin
          o = blank(S_MEMWB);
          o.rw  = 1'b1;
          o.m2r = 1'b1;
          add(rnd_op(), rnd_bit(), 1'b0, o);
        end
      end
      6'b000000, 6'b001000: begin
        o = blank(op == 6'b000000 ? S_EXEC : S_IEXEC);
        o.asa = 1'b1;
        if (op == 6'b000000) o.aluop = 2'b10;
        else                 o.asb   = 2'b10;
        add(rnd_op(), rnd_bit(), 1'b0, o);
        o = blank(op == 6'b000000 ? S_RWB : S_IWB);
        o.rw = 1'b1;
        o.rd = (op == 6'b000000);
        add(rnd_op(), rnd_bit(), 1'b0, o);
      end
      6'b000100, 6'b000101: begin
        o = blank(S_BRANCH);
        o.asa   = 1'b1;
        o.aluop = 2'b01;
        o.pcwc  = 1'b1;
        o.pcs   = 2'b01;
        o.bne   = (op == 6'b000101);
        add(rnd_op(), rnd_bit(), 1'b0, o);
      end
      6'b000010: begin
        o = blank(S_JUMP);
        o.pcw = 1'b1;
        o.pcs = 2'b10;
        add(rnd_op(), rnd_bit(), 1'b0, o);
      end
      default: begin
        o = blank(S_HALT);
        o.halted = 1'b1;
        for (int h = 0; h < halt_cycles; h++) add(rnd_op(), rnd_bit(), 1'b0, o);
        add(rnd_op(), rnd_bit(), 1'b1, o);
      end
    endcase
  endtask

  function automatic logic [5:0] rnd_illegal();
    logic [5:0] v;
    do v = rnd_op();
    while (v inside {6'b000000, 6'b000010, 6'b000100, 6'b000101,
                     6'b001000, 6'b100011, 6'b101011});
    return v;
  endfunction

  logic [5:0] legal [7];

  initial begin
    legal = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000, 6'b100011, 6'b101011};
    reset = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b0;

    add(rnd_op(), 1'b1, 1'b1, fetch_o(1'b1));
    do_instr(6'b100011, 0, 0, -1, 0);
    do_instr(6'b101011, 0, 3, -1, 0);
    do_instr(6'b000101, 0, 0, -1, 0);
    do_instr(6'b000100, 0, 0, -1, 0);
    do_instr(6'b000000, 0, 0, -1, 0);
    do_instr(6'b001000, 0, 0, -1, 0);
    do_instr(6'b000010, 0, 0, -1, 0);
    do_instr(6'b100011, 2, 0, -1, 0);
    do_instr(6'b100011, 0, 3, 1, 0);
    do_instr(6'b101011, 1, 2, 0, 0);
    for (int i = 0; i < 60; i++)
      do_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);
    do_instr(6'b111111, 0, 0, -1, 20);
    do_instr(6'b000101, 0, 0, -1, 0);
    do_instr(rnd_illegal(), 1, 0, -1, 3);
    for (int i = 0; i < 5; i++)
      do_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);

    @(posedge clock);
    foreach (plan[i]) begin
      @(posedge clock);
      #1;
      opcode    = plan[i].op;
      mem_ready = plan[i].rdy;
      reset     = plan[i].rst;
      exp_q.push_back(plan[i].e);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  obs_t m_exp, m_act;
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        m_act = '{st: state, halted: halted, pcw: PCWrite, pcwc: PCWriteCond,
                  bne: BranchNe, iord: IorD, mr: MemRead, mw: MemWrite,
                  irw: IRWrite, m2r: MemtoReg, rd: RegDst, rw: RegWrite,
                  asa: ALUSrcA, aluop: ALUOp, asb: ALUSrcB, pcs: PCSource};
        n_checks++;
        if (m_act === m_exp) n_pass++;
        else $display("FAIL ctrl @%0t: got %h (state %0d), required %h (state %0d)",
                      $time, m_act, m_act.st, m_exp, m_exp.st);
        n_checks++;
        if ((MemRead & MemWrite) === 1'b0) n_pass++;
        else $display("FAIL mem_excl @%0t: MemRead=%b MemWrite=%b, required not both 1",
                      $time, MemRead, MemWrite);
      end
    end
  end

endmodule
